// File: rtl/ps2_key_rx_if.sv
// Bus bundle between the PS/2 keyboard receiver and the game logic that consumes its decoded keys.
// code_valid is a one-cycle strobe with no ready/back-pressure: code, brk and ext are meaningful
// in the strobe cycle and hold until the next strobe, so a consumer must sample on code_valid.
interface ps2_key_rx_if;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] code;
    logic       code_valid;
    logic       brk;
    logic       ext;
    logic       up_pulse;
    logic       up_held;
    logic       mode;
    logic       frame_err;

    modport master (
        input  ps2_clk,
        input  ps2_data,
        output code,
        output code_valid,
        output brk,
        output ext,
        output up_pulse,
        output up_held,
        output mode,
        output frame_err
    );

    modport slave (
        output ps2_clk,
        output ps2_data,
        input  code,
        input  code_valid,
        input  brk,
        input  ext,
        input  up_pulse,
        input  up_held,
        input  mode,
        input  frame_err
    );
endinterface

// File: rtl/ps2_key_rx.sv
// PS/2 keyboard receiver: frames bytes, folds E0/F0 prefixes and drives game up/mode controls.
// Define PS2_PARITY_CHECK_EN to reject frames with even parity; otherwise parity is ignored.
module ps2_key_rx #(
    parameter int         TIMEOUT_CYC = 100000,
    parameter logic [7:0] UP_CODE     = 8'h29,
    parameter logic [7:0] MODE_CODE   = 8'h3A
) (
    input  logic            clk,
    input  logic            rst_n,
    ps2_key_rx_if.master    bus,
    output logic [1:0]      state_dbg,
    output logic            parity_ok_dbg
);

    localparam int             CW      = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CW-1:0]  TO_LAST = CW'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DATA   = 2'd1,
        S_PARITY = 2'd2,
        S_STOP   = 2'd3
    } state_t;

    state_t        state;
    logic          clk_s1, clk_s2, clk_d;
    logic          dat_s1, dat_s2;
    logic          fall;
    logic [7:0]    shreg;
    logic [2:0]    bit_cnt;
    logic          par_bit;
    logic [CW-1:0] to_cnt;
    logic          brk_f, ext_f;
    logic          parity_ok;
    logic          frame_good;
    logic          timeout;

    // Synchronizers reset to the idle-high bus level so reset release never looks like a fall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_s1 <= 1'b1;
            clk_s2 <= 1'b1;
            clk_d  <= 1'b1;
            dat_s1 <= 1'b1;
            dat_s2 <= 1'b1;
        end else begin
            clk_s1 <= bus.ps2_clk;
            clk_s2 <= clk_s1;
            clk_d  <= clk_s2;
            dat_s1 <= bus.ps2_data;
            dat_s2 <= dat_s1;
        end
    end

    assign fall      = clk_d & ~clk_s2;
    assign parity_ok = ^{shreg, par_bit};

`ifdef PS2_PARITY_CHECK_EN
    assign frame_good = dat_s2 & parity_ok;
`else
    assign frame_good = dat_s2;
`endif

    // A fall in the same cycle wins over the timeout.
    assign timeout = (state != S_IDLE) && !fall && (to_cnt == TO_LAST);

    assign state_dbg     = state;
    assign parity_ok_dbg = parity_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            shreg          <= 8'h00;
            bit_cnt        <= 3'd0;
            par_bit        <= 1'b0;
            to_cnt         <= '0;
            brk_f          <= 1'b0;
            ext_f          <= 1'b0;
            bus.code       <= 8'h00;
            bus.code_valid <= 1'b0;
            bus.brk        <= 1'b0;
            bus.ext        <= 1'b0;
            bus.up_pulse   <= 1'b0;
            bus.up_held    <= 1'b0;
            bus.mode       <= 1'b0;
            bus.frame_err  <= 1'b0;
        end else begin
            bus.code_valid <= 1'b0;
            bus.up_pulse   <= 1'b0;
            bus.frame_err  <= 1'b0;

            if (state == S_IDLE || fall) begin
                to_cnt <= '0;
            end else begin
                to_cnt <= to_cnt + 1'b1;
            end

            if (timeout) begin
                state         <= S_IDLE;
                bus.frame_err <= 1'b1;
            end else if (fall) begin
                case (state)
                    S_IDLE: begin
                        if (!dat_s2) begin
                            state   <= S_DATA;
                            bit_cnt <= 3'd0;
                        end
                    end
                    S_DATA: begin
                        shreg   <= {dat_s2, shreg[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            state <= S_PARITY;
                        end
                    end
                    S_PARITY: begin
                        par_bit <= dat_s2;
                        state   <= S_STOP;
                    end
                    S_STOP: begin
                        state <= S_IDLE;
                        if (!frame_good) begin
                            bus.frame_err <= 1'b1;
                        end else if (shreg == 8'hF0) begin
                            brk_f <= 1'b1;
                        end else if (shreg == 8'hE0) begin
                            ext_f <= 1'b1;
                        end else begin
                            bus.code       <= shreg;
                            bus.brk        <= brk_f;
                            bus.ext        <= ext_f;
                            bus.code_valid <= 1'b1;
                            brk_f          <= 1'b0;
                            ext_f          <= 1'b0;
                            // Extended keys share scan codes with the game keys and must not alias them.
                            if (!ext_f && shreg == UP_CODE) begin
                                bus.up_held  <= !brk_f;
                                bus.up_pulse <= !brk_f;
                            end
                            if (!ext_f && !brk_f && shreg == MODE_CODE) begin
                                bus.mode <= !bus.mode;
                            end
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ps2_key_rx.sv
// Randomized bench for ps2_key_rx: frames are driven bit by bit and a prefix-folding model predicts every strobe and level.
module tb_ps2_key_rx;

    localparam int         TMO       = 2000;
    localparam logic [7:0] UP_CODE   = 8'h29;
    localparam logic [7:0] MODE_CODE = 8'h3A;

    typedef struct packed {
        logic       is_err;
        logic [7:0] code;
        logic       brk;
        logic       ext;
        logic       up_pulse;
        logic       up_held;
        logic       mode;
    } ev_t;

    logic        clk;
    logic        rst_n;
    logic [1:0]  state_dbg;
    logic        parity_ok_dbg;

    ps2_key_rx_if bus ();

    ps2_key_rx #(
        .TIMEOUT_CYC (TMO),
        .UP_CODE     (UP_CODE),
        .MODE_CODE   (MODE_CODE)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .bus           (bus.master),
        .state_dbg     (state_dbg),
        .parity_ok_dbg (parity_ok_dbg)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #(10 * 150000);
        $display("FAIL watchdog: simulation did not finish, got timeout, required normal end");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    logic [13:0] exp_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          n_valid  = 0;
    int          n_err    = 0;
    int          n_up     = 0;
    int          half_p   = 12;

    // model of the prefix flags and game levels, advanced when a frame is driven
    logic        m_brk_f, m_ext_f, m_up_held, m_mode;
    // expected output levels, advanced when the DUT strobes
    logic [7:0]  cur_code;
    logic        cur_brk, cur_ext, cur_up_held, cur_mode;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_brk_f   = 1'b0;
        m_ext_f   = 1'b0;
        m_up_held = 1'b0;
        m_mode    = 1'b0;
    endfunction

    // Predict the effect of one complete frame from the protocol rules.
    function automatic void model_frame(input logic [7:0] b, input logic par, input logic stop);
        ev_t  e;
        logic good;
`ifdef PS2_PARITY_CHECK_EN
        good = stop && (((^b) ^ par) == 1'b1);
`else
        good = stop;
`endif
        e = '0;
        if (!good) begin
            e.is_err = 1'b1;
            exp_q.push_back(e);
        end else if (b == 8'hF0) begin
            m_brk_f = 1'b1;
        end else if (b == 8'hE0) begin
            m_ext_f = 1'b1;
        end else begin
            e.code     = b;
            e.brk      = m_brk_f;
            e.ext      = m_ext_f;
            e.up_pulse = (b == UP_CODE) && !m_ext_f && !m_brk_f;
            if (b == UP_CODE && !m_ext_f) m_up_held = !m_brk_f;
            if (b == MODE_CODE && !m_ext_f && !m_brk_f) m_mode = !m_mode;
            e.up_held  = m_up_held;
            e.mode     = m_mode;
            exp_q.push_back(e);
            m_brk_f = 1'b0;
            m_ext_f = 1'b0;
        end
    endfunction

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        ev_t e;
        if (!rst_n) begin
            cur_code    <= 8'h00;
            cur_brk     <= 1'b0;
            cur_ext     <= 1'b0;
            cur_up_held <= 1'b0;
            cur_mode    <= 1'b0;
        end else begin
            if (bus.code_valid) n_valid++;
            if (bus.frame_err)  n_err++;
            if (bus.up_pulse)   n_up++;
            if (bus.code_valid || bus.frame_err) begin
                chk("strobe_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = ev_t'(exp_q.pop_front());
                    chk("strobe_kind", {30'd0, bus.code_valid, bus.frame_err},
                        e.is_err ? 32'd1 : 32'd2);
                    chk("up_pulse", 32'(bus.up_pulse), 32'(e.up_pulse));
                    if (!e.is_err) begin
                        chk("levels_at_valid",
                            {20'd0, bus.code, bus.brk, bus.ext, bus.up_held, bus.mode},
                            {20'd0, e.code, e.brk, e.ext, e.up_held, e.mode});
                        cur_code    <= e.code;
                        cur_brk     <= e.brk;
                        cur_ext     <= e.ext;
                        cur_up_held <= e.up_held;
                        cur_mode    <= e.mode;
                    end else begin
                        chk("levels_at_err",
                            {20'd0, bus.code, bus.brk, bus.ext, bus.up_held, bus.mode},
                            {20'd0, cur_code, cur_brk, cur_ext, cur_up_held, cur_mode});
                    end
                end
            end else begin
                chk("up_pulse_quiet", 32'(bus.up_pulse), 32'd0);
                chk("levels_hold",
                    {20'd0, bus.code, bus.brk, bus.ext, bus.up_held, bus.mode},
                    {20'd0, cur_code, cur_brk, cur_ext, cur_up_held, cur_mode});
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic v);
        bus.ps2_data = v;
        wait_cyc(half_p);
        bus.ps2_clk = 1'b0;
        wait_cyc(half_p);
        bus.ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic stop);
        logic par;
        par = (~^b) ^ bad_par;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(par);
        model_frame(b, par, stop);
        send_bit(stop);
        bus.ps2_data = 1'b1;
        wait_cyc(half_p + 8);
        chk("drain", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        model_reset();
        chk("reset_outputs",
            {18'd0, bus.code, bus.code_valid, bus.brk, bus.ext, bus.up_pulse,
             bus.up_held, bus.mode, bus.frame_err},
            32'd0);
        wait_cyc(4);
        rst_n = 1'b1;
        wait_cyc(4);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int v0, e0, u0;
        logic [7:0] b;
        rst_n        = 1'b0;
        bus.ps2_clk  = 1'b1;
        bus.ps2_data = 1'b1;
        model_reset();
        wait_cyc(3);
        apply_reset();

        // single make of the up key
        u0 = n_up; v0 = n_valid;
        send_frame(8'h29, 1'b0, 1'b1);
        chk("d_make_code", 32'(bus.code), 32'h29);
        chk("d_make_flags", {30'd0, bus.brk, bus.ext}, 32'd0);
        chk("d_make_up_held", 32'(bus.up_held), 32'd1);
        chk("d_make_pulses", 32'(n_up - u0), 32'd1);
        chk("d_make_valids", 32'(n_valid - v0), 32'd1);

        // release of the up key
        u0 = n_up; v0 = n_valid;
        send_frame(8'hF0, 1'b0, 1'b1);
        send_frame(8'h29, 1'b0, 1'b1);
        chk("d_break_valids", 32'(n_valid - v0), 32'd1);
        chk("d_break_code_brk", {23'd0, bus.code, bus.brk}, {23'd0, 8'h29, 1'b1});
        chk("d_break_up_held", 32'(bus.up_held), 32'd0);
        chk("d_break_pulses", 32'(n_up - u0), 32'd0);

        // wrong parity on the up key
        v0 = n_valid; e0 = n_err;
        send_frame(8'h29, 1'b1, 1'b1);
`ifdef PS2_PARITY_CHECK_EN
        chk("d_parity_err", 32'(n_err - e0), 32'd1);
        chk("d_parity_valid", 32'(n_valid - v0), 32'd0);
`else
        chk("d_parity_err", 32'(n_err - e0), 32'd0);
        chk("d_parity_valid", 32'(n_valid - v0), 32'd1);
        chk("d_parity_code", 32'(bus.code), 32'h29);
`endif

        // missing stop bit
        e0 = n_err;
        send_frame(8'h3A, 1'b0, 1'b0);
        chk("d_stop_err", 32'(n_err - e0), 32'd1);

        // mode toggling: make, break, make
        send_frame(8'h3A, 1'b0, 1'b1);
        chk("d_mode_1", 32'(bus.mode), 32'd1);
        send_frame(8'hF0, 1'b0, 1'b1);
        send_frame(8'h3A, 1'b0, 1'b1);
        chk("d_mode_2", {30'd0, bus.mode, bus.brk}, 32'd3);
        send_frame(8'h3A, 1'b0, 1'b1);
        chk("d_mode_3", 32'(bus.mode), 32'd0);

        // extended key sharing the up code
        u0 = n_up;
        send_frame(8'hE0, 1'b0, 1'b1);
        send_frame(8'h29, 1'b0, 1'b1);
        chk("d_ext_flag", {30'd0, bus.ext, bus.brk}, 32'd2);
        chk("d_ext_pulses", 32'(n_up - u0), 32'd0);

        // partial frame abandoned on the wire
        e0 = n_err;
        send_bit(1'b0);
        for (int i = 0; i < 5; i++) send_bit(1'(i & 1));
        begin
            ev_t e;
            e = '0;
            e.is_err = 1'b1;
            exp_q.push_back(e);
        end
        wait_cyc(TMO + 40);
        chk("d_timeout_drain", 32'(exp_q.size()), 32'd0);
        chk("d_timeout_errs", 32'(n_err - e0), 32'd1);
        u0 = n_up;
        send_frame(8'h29, 1'b0, 1'b1);
        chk("d_after_timeout", {23'd0, bus.code, bus.up_held}, {23'd0, 8'h29, 1'b1});
        chk("d_after_timeout_pulse", 32'(n_up - u0), 32'd1);

        // reset in the middle of a frame, after data bit 4
        send_bit(1'b0);
        for (int i = 0; i < 5; i++) send_bit(1'(~i & 1));
        apply_reset();
        send_frame(8'h3A, 1'b0, 1'b1);
        chk("d_post_reset", {23'd0, bus.code, bus.mode}, {23'd0, 8'h3A, 1'b1});

        // randomized traffic
        for (int n = 0; n < 60; n++) begin
            half_p = $urandom_range(8, 25);
            case ($urandom_range(0, 9))
                0, 1:    b = UP_CODE;
                2, 3:    b = MODE_CODE;
                4:       b = 8'hF0;
                5:       b = 8'hE0;
                default: b = 8'($urandom_range(0, 255));
            endcase
            send_frame(b, ($urandom_range(0, 7) == 0), ($urandom_range(0, 9) != 0));
            wait_cyc($urandom_range(0, 30));
        end

        wait_cyc(20);
        chk("final_drain", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/ps2_key_rx.md
PS2_KEY_RX -- requirements
Module: ps2_key_rx

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 100000, meaning: clk cycles without a PS/2 falling edge before a partial frame is aborted.
REQ-002 SHALL have parameter UP_CODE, default 8'h29, meaning: scan code (Space) mapped to the game "up" input.
REQ-003 SHALL have parameter MODE_CODE, default 8'h3A, meaning: scan code (M) mapped to the game mode toggle.
REQ-004 SHALL have port clk, input, 1, meaning: system clock, 100 MHz board clock, all logic on the rising edge.
REQ-005 SHALL have port rst_n, input, 1, meaning: asynchronous active-low reset.
REQ-006 SHALL have port ps2_clk, input, 1, meaning: PS/2 device clock, asynchronous, idle high.
REQ-007 SHALL have port ps2_data, input, 1, meaning: PS/2 device data, asynchronous, idle high.
REQ-008 SHALL have port code, output, 8, meaning: last decoded scan code, excluding E0/F0 prefixes.
REQ-009 SHALL have port code_valid, output, 1, meaning: one-cycle strobe qualifying code, brk and ext.
REQ-010 SHALL have port brk, output, 1, meaning: code was preceded by F0 (key release).
REQ-011 SHALL have port ext, output, 1, meaning: code was preceded by E0.
REQ-012 SHALL have port up_pulse, output, 1, meaning: one-cycle strobe on each non-extended make of UP_CODE, typematic repeats included.
REQ-013 SHALL have port up_held, output, 1, meaning: level, high from make to break of UP_CODE.
REQ-014 SHALL have port mode, output, 1, meaning: level, toggled on each non-extended make of MODE_CODE.
REQ-015 SHALL have port frame_err, output, 1, meaning: one-cycle strobe on parity, stop-bit or timeout failure.

Function
REQ-016 SHALL synchronize ps2_clk and ps2_data through two flops each, and derive fall as (previous synced clk high AND current synced clk low).
REQ-017 SHALL implement the FSM IDLE -> DATA -> PARITY -> STOP -> IDLE, advancing only on cycles where fall=1.
REQ-018 In IDLE, on fall with synced data=0 (start bit), the FSM SHALL go to DATA and clear the bit counter; with data=1 it SHALL stay in IDLE with no error.
REQ-019 In DATA, the FSM SHALL shift 8 bits LSB first and go to PARITY after the 8th bit.
REQ-020 In PARITY, the FSM SHALL store the bit; in STOP, the frame is good when stop=1 and the parity check passes (REQ-033).
REQ-021 On a bad frame, the block SHALL pulse frame_err in the cycle after the STOP fall, discard the byte and leave the prefix flags unchanged.
REQ-022 In any state other than IDLE, a counter SHALL clear on each fall; on reaching TIMEOUT_CYC, the FSM SHALL return to IDLE and pulse frame_err once.
REQ-023 For a good byte F0, the block SHALL set the internal brk flag; for E0, the internal ext flag; neither raises code_valid.
REQ-024 For any other good byte, the block SHALL drive code, brk and ext, and pulse code_valid in the cycle after the STOP fall; internal flags clear in that same cycle.
REQ-025 up_pulse, up_held and mode SHALL update in the same cycle as code_valid; brk on UP_CODE SHALL clear up_held; extended codes SHALL affect none of these.
REQ-026 Outputs code, brk and ext SHALL hold their values until the next code_valid.
REQ-027 A fall coincident with a timeout SHALL take priority, so no timeout fires in that cycle.

Reset
REQ-028 rst_n low SHALL asynchronously force FSM=IDLE and clear the counters and shift register.
REQ-029 rst_n low SHALL clear the internal brk/ext flags and drive code=0, brk=0, ext=0, code_valid=0, up_pulse=0, up_held=0, mode=0 and frame_err=0.
REQ-030 The synchronizer flops SHALL reset to 1 (idle bus), so no spurious fall occurs after reset release.
REQ-031 After a reset mid-frame, the block SHALL require a fresh start bit; the remainder of the interrupted frame is dropped or flagged as timeout, never decoded.

Configuration
REQ-032 Macro PS2_PARITY_CHECK_EN SHALL select the parity behaviour.
REQ-033 With PS2_PARITY_CHECK_EN defined, a frame SHALL be good only if the 8 data bits plus the parity bit contain an odd number of ones.
REQ-034 Without PS2_PARITY_CHECK_EN, the parity bit SHALL be sampled and ignored; only the stop bit and timeout can raise frame_err.

Verification
REQ-035 Frame 0x29 (parity 0, stop 1) -> code=0x29, brk=0, ext=0, code_valid=1 and up_pulse=1 for one cycle, up_held=1.
REQ-036 Frames F0, 29 -> one code_valid with code=0x29, brk=1; up_held=0; no up_pulse.
REQ-037 Frame 0x29 with parity 1 -> with macro defined: frame_err=1, no code_valid; without the macro: code_valid, code=0x29.
REQ-038 Frames 3A, F0, 3A, 3A -> mode goes 0->1->1->0; E0, 29 -> ext=1, no up_pulse.
REQ-039 Start bit plus 5 data bits, then the bus idles for TIMEOUT_CYC cycles -> one frame_err; the next frame 0x29 decodes correctly.
REQ-040 rst_n pulsed low after bit 4 of a frame -> all outputs 0 immediately; the following full frame 0x3A -> code=0x3A, mode=1.
